regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 `registerFile`. It shares the single write port (WE3/A3/WD3) between two requesters: the in-order pipeline writeback and the long-latency unit (mul/div, load miss). It tracks outstanding long-latency destinations in a busy scoreboard for the hazard unit. It sits between the writeback stage and `registerFile`, and its write-port outputs drive `WE3`, `i_A3_addr` and `i_WD3_data` directly.

---
 rtl/regfile_wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single write port (WE3/A3/WD3) of the 32x32 register file
//   between two requesters:
//     - the in-order pipeline writeback (wb)
//     - the long-latency unit (ll: mul/div, load miss)
//   It also keeps a busy scoreboard of the ll destinations that are still
//   outstanding, for use by the hazard unit.
//   The write-port outputs are registered and drive the register file
//   directly.
//
// Arbitration:
//   wb normally wins over ll.
//   With WB_ARB_STARVE_EN defined, a 4-bit wait counter tracks how many
//   consecutive cycles ll has lost. Once the count reaches STARVE_LIMIT, ll is
//   forced through and the pipeline is stalled for that one cycle.
//   Without the macro, ll is granted only in cycles where wb is idle, and
//   STARVE_LIMIT is ignored.
//
// Handshake (ll port):
//   A transfer occurs in a cycle where i_ll_valid && o_ll_ready.
//   The ll unit holds i_ll_valid, i_ll_rd and i_ll_data stable until that
//   transfer, and never drops i_ll_valid before it.
//   The wb request has no ready signal. It is consumed in every cycle where
//   o_wb_stall is low, and ignored while o_wb_stall is high.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_wb_valid/i_wb_rd/i_wb_data pipeline writeback request
//   o_wb_stall                   pipeline must hold its writeback
//   i_ll_issue/i_ll_issue_rd     ll op issued; marks destination busy
//   i_ll_valid/i_ll_rd/i_ll_data ll result request
//   o_ll_ready                   ll granted this cycle (combinational)
//   o_WE3/o_A3_addr/o_WD3_data   registered register-file write port
//   o_busy                       scoreboard of uncommitted ll destinations
//
// Parameter:
//   STARVE_LIMIT  1..15; used only when WB_ARB_STARVE_EN is defined.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  input  logic        i_ll_issue,
  input  logic [4:0]  i_ll_issue_rd,
  input  logic        i_ll_valid,
  input  logic [4:0]  i_ll_rd,
  input  logic [31:0] i_ll_data,
  output logic        o_ll_ready,
  output logic        o_WE3,
  output logic [4:0]  o_A3_addr,
  output logic [31:0] o_WD3_data,
  output logic [31:0] o_busy
);

  logic        force_ll;
  logic        grant_ll;
  logic        grant_wb;

  logic        we_q;
  logic        we_d;
  logic [4:0]  addr_q;
  logic [4:0]  addr_d;
  logic [31:0] data_q;
  logic [31:0] data_d;
  logic        ll_commit_q;
  logic        ll_commit_d;
  logic [31:0] busy_q;
  logic [31:0] busy_d;

`ifdef WB_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;

  // Decoded from the registered counter only, so stall is glitch-free.
  assign force_ll = (wait_cnt_q == LIMIT);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_ll_valid || grant_ll) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign force_ll = 1'b0;
`endif

  // The two grants are mutually exclusive:
  //   - When force_ll is high, wb cannot win.
  //   - When force_ll is low, ll needs wb to be idle.
  assign grant_ll = i_ll_valid && (force_ll || !i_wb_valid);
  assign grant_wb = i_wb_valid && !force_ll;

  // Mask ready during reset so the ll unit never sees a transfer in reset.
  assign o_ll_ready = i_rst_n && grant_ll;
  assign o_wb_stall = force_ll;

  // Write register.
  // The winner's rd and data are loaded on any grant. A write to x0 is
  // consumed but never asserts the enable. Address and data hold their
  // values when there is no grant.
  always_comb begin
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    ll_commit_d = 1'b0;
    if (grant_ll) begin
      we_d        = (i_ll_rd != 5'd0);
      addr_d      = i_ll_rd;
      data_d      = i_ll_data;
      ll_commit_d = 1'b1;
    end else if (grant_wb) begin
      we_d        = (i_wb_rd != 5'd0);
      addr_d      = i_wb_rd;
      data_d      = i_wb_data;
    end
  end

  // Scoreboard.
  // A busy bit is cleared on the edge where the register file captures the
  // ll write. The set is applied after the clear, so a re-issue of the same
  // register on that edge wins and the bit stays set.
  always_comb begin
    busy_d = busy_q;
    if (we_q && ll_commit_q) begin
      busy_d[addr_q] = 1'b0;
    end
    if (i_ll_issue && (i_ll_issue_rd != 5'd0)) begin
      busy_d[i_ll_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= 5'd0;
      data_q      <= 32'd0;
      ll_commit_q <= 1'b0;
      busy_q      <= 32'd0;
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ll_commit_q <= ll_commit_d;
      busy_q      <= busy_d;
    end
  end

  assign o_WE3      = we_q;
  assign o_A3_addr  = addr_q;
  assign o_WD3_data = data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Testbench for regfile_wb_arbiter, built with STARVE_LIMIT = 4.
//
// Reference model:
//   A cycle-level model of the arbiter, written in terms of its observable
//   behaviour:
//     - ll loses to wb until it has lost LIMIT times in a row (starvation
//       build only); after that it wins.
//     - The winner appears on the write port one cycle later.
//     - ll destinations stay busy until their write commits.
//
// Checking:
//   - A compare process checks every DUT output against the model on each
//     falling edge while reset is released.
//   - Directed sequences add hand-computed literal expectations.
//
// The starvation behaviour follows WB_ARB_STARVE_EN, exactly as in the design.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------------------
  // DUT signals and instance
  // ---------------------------------------------------------------------------
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_wb_stall;
  logic        i_ll_issue;
  logic [4:0]  i_ll_issue_rd;
  logic        i_ll_valid;
  logic [4:0]  i_ll_rd;
  logic [31:0] i_ll_data;
  logic        o_ll_ready;
  logic        o_WE3;
  logic [4:0]  o_A3_addr;
  logic [31:0] o_WD3_data;
  logic [31:0] o_busy;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wb_valid    (i_wb_valid),
    .i_wb_rd       (i_wb_rd),
    .i_wb_data     (i_wb_data),
    .o_wb_stall    (o_wb_stall),
    .i_ll_issue    (i_ll_issue),
    .i_ll_issue_rd (i_ll_issue_rd),
    .i_ll_valid    (i_ll_valid),
    .i_ll_rd       (i_ll_rd),
    .i_ll_data     (i_ll_data),
    .o_ll_ready    (o_ll_ready),
    .o_WE3         (o_WE3),
    .o_A3_addr     (o_A3_addr),
    .o_WD3_data    (o_WD3_data),
    .o_busy        (o_busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_from_ll;
  int          m_losses;   // consecutive cycles the pending ll has lost

  function automatic bit m_force();
    return STARVE_ON && (m_losses >= LIMIT);
  endfunction

  function automatic bit m_ll_wins();
    return i_ll_valid && (m_force() || !i_wb_valid);
  endfunction

  function automatic bit m_wb_wins();
    return i_wb_valid && !m_force();
  endfunction

  function automatic logic [31:0] m_busy_next();
    logic [31:0] b;
    b = m_busy;
    if (m_we && m_from_ll) b[m_addr] = 1'b0;
    if (i_ll_issue && i_ll_issue_rd != 5'd0) b[i_ll_issue_rd] = 1'b1;
    return b;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy    <= '0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
      m_from_ll <= 1'b0;
      m_losses  <= 0;
    end else begin
      m_busy <= m_busy_next();
      if (m_ll_wins()) begin
        m_we      <= (i_ll_rd != 5'd0);
        m_addr    <= i_ll_rd;
        m_data    <= i_ll_data;
        m_from_ll <= 1'b1;
      end else if (m_wb_wins()) begin
        m_we      <= (i_wb_rd != 5'd0);
        m_addr    <= i_wb_rd;
        m_data    <= i_wb_data;
        m_from_ll <= 1'b0;
      end else begin
        m_we      <= 1'b0;
        m_from_ll <= 1'b0;
      end
      if (!i_ll_valid || m_ll_wins()) m_losses <= 0;
      else                            m_losses <= m_losses + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1) begin
      chk("ll_ready", {31'd0, o_ll_ready}, {31'd0, m_ll_wins()});
      chk("wb_stall", {31'd0, o_wb_stall}, {31'd0, m_force()});
      chk("WE3",      {31'd0, o_WE3},      {31'd0, m_we});
      chk("A3",       {27'd0, o_A3_addr},  {27'd0, m_addr});
      chk("WD3",      o_WD3_data,          m_data);
      chk("busy",     o_busy,              m_busy);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_wb_valid    = 1'b0;
    i_wb_rd       = '0;
    i_wb_data     = '0;
    i_ll_issue    = 1'b0;
    i_ll_issue_rd = '0;
    i_ll_valid    = 1'b0;
    i_ll_rd       = '0;
    i_ll_data     = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [15:0] wb_pat;
  bit          g;

  initial begin
    idle_inputs();

    // Reset with an ll request present.
    i_rst_n    = 1'b0;
    i_ll_valid = 1'b1;
    i_ll_rd    = 5'd4;
    i_ll_data  = 32'h4444;
    repeat (2) @(negedge i_clk);
    chk("rst_WE3",      {31'd0, o_WE3},      32'd0);
    chk("rst_A3",       {27'd0, o_A3_addr},  32'd0);
    chk("rst_WD3",      o_WD3_data,          32'd0);
    chk("rst_busy",     o_busy,              32'd0);
    chk("rst_ll_ready", {31'd0, o_ll_ready}, 32'd0);
    chk("rst_wb_stall", {31'd0, o_wb_stall}, 32'd0);
    #1;
    i_rst_n = 1'b1;
    idle_inputs();

    // wb only.
    cyc();
    i_wb_valid = 1'b1;
    i_wb_rd    = 5'd5;
    i_wb_data  = 32'h55;
    cyc();
    i_wb_valid = 1'b0;
    @(negedge i_clk);
    chk("wb_WE3", {31'd0, o_WE3},     32'd1);
    chk("wb_A3",  {27'd0, o_A3_addr}, 32'd5);
    chk("wb_WD3", o_WD3_data,         32'h55);
    cyc();
    @(negedge i_clk);
    chk("wb_WE3_off", {31'd0, o_WE3}, 32'd0);

    // Contention: wb wins, then ll goes through once wb is idle.
    cyc();
    i_wb_valid = 1'b1;
    i_wb_rd    = 5'd3;
    i_wb_data  = 32'h33;
    i_ll_valid = 1'b1;
    i_ll_rd    = 5'd7;
    i_ll_data  = 32'h77;
    @(negedge i_clk);
    chk("cont_ll_ready0", {31'd0, o_ll_ready}, 32'd0);
    cyc();
    i_wb_valid = 1'b0;
    @(negedge i_clk);
    chk("cont_A3_wb",     {27'd0, o_A3_addr},  32'd3);
    chk("cont_WD3_wb",    o_WD3_data,          32'h33);
    chk("cont_ll_ready1", {31'd0, o_ll_ready}, 32'd1);
    cyc();
    i_ll_valid = 1'b0;
    @(negedge i_clk);
    chk("cont_A3_ll",  {27'd0, o_A3_addr}, 32'd7);
    chk("cont_WD3_ll", o_WD3_data,         32'h77);
    chk("cont_WE3_ll", {31'd0, o_WE3},     32'd1);

    // Starvation: wb held high, ll rd 9 pending.
    cyc();
    i_wb_valid = 1'b1;
    i_wb_rd    = 5'd2;
    i_wb_data  = 32'h22;
    i_ll_valid = 1'b1;
    i_ll_rd    = 5'd9;
    i_ll_data  = 32'h99;
    for (int k = 1; k <= 5; k++) begin
      @(negedge i_clk);
      if (k < 5) begin
        chk("starve_stall_lo", {31'd0, o_wb_stall}, 32'd0);
        chk("starve_ready_lo", {31'd0, o_ll_ready}, 32'd0);
      end else begin
        chk("starve_stall_c5", {31'd0, o_wb_stall}, {31'd0, STARVE_ON});
        chk("starve_ready_c5", {31'd0, o_ll_ready}, {31'd0, STARVE_ON});
      end
      cyc();
      if (k == 5 && STARVE_ON) i_ll_valid = 1'b0;
    end
    @(negedge i_clk);
    chk("starve_stall_c6", {31'd0, o_wb_stall}, 32'd0);
`ifdef WB_ARB_STARVE_EN
    chk("starve_A3_c6", {27'd0, o_A3_addr}, 32'd9);
    cyc();
    i_wb_valid = 1'b0;
`else
    chk("starve_A3_c6", {27'd0, o_A3_addr}, 32'd2);
    cyc();
    i_wb_valid = 1'b0;
    @(negedge i_clk);
    chk("nostarve_ready", {31'd0, o_ll_ready}, 32'd1);
    cyc();
    i_ll_valid = 1'b0;
    @(negedge i_clk);
    chk("nostarve_A3", {27'd0, o_A3_addr}, 32'd9);
`endif

    // Scoreboard: set, clear with a re-issue on the same edge, then a plain clear.
    cyc();
    i_ll_issue    = 1'b1;
    i_ll_issue_rd = 5'd12;
    cyc();
    i_ll_issue = 1'b0;
    @(negedge i_clk);
    chk("sb_set", {31'd0, o_busy[12]}, 32'd1);
    cyc();
    i_ll_valid = 1'b1;
    i_ll_rd    = 5'd12;
    i_ll_data  = 32'hC0C0;
    cyc();
    i_ll_valid    = 1'b0;
    i_ll_issue    = 1'b1;
    i_ll_issue_rd = 5'd12;
    @(negedge i_clk);
    chk("sb_we_12",  {31'd0, o_WE3},      32'd1);
    chk("sb_a3_12",  {27'd0, o_A3_addr},  32'd12);
    cyc();
    i_ll_issue = 1'b0;
    @(negedge i_clk);
    chk("sb_reissue", {31'd0, o_busy[12]}, 32'd1);
    cyc();
    i_ll_valid = 1'b1;
    i_ll_data  = 32'hC1C1;
    cyc();
    i_ll_valid = 1'b0;
    @(negedge i_clk);
    chk("sb_still_busy", {31'd0, o_busy[12]}, 32'd1);
    cyc();
    @(negedge i_clk);
    chk("sb_clear", o_busy, 32'd0);

    // x0 handling.
    cyc();
    i_wb_valid = 1'b1;
    i_wb_rd    = 5'd0;
    i_wb_data  = 32'hDEADBEEF;
    cyc();
    i_wb_valid = 1'b0;
    @(negedge i_clk);
    chk("x0_wb_WE3", {31'd0, o_WE3}, 32'd0);
    cyc();
    i_ll_issue    = 1'b1;
    i_ll_issue_rd = 5'd0;
    cyc();
    i_ll_issue = 1'b0;
    @(negedge i_clk);
    chk("x0_busy", o_busy, 32'd0);
    cyc();
    i_ll_valid = 1'b1;
    i_ll_rd    = 5'd0;
    i_ll_data  = 32'h1234;
    @(negedge i_clk);
    chk("x0_ll_ready", {31'd0, o_ll_ready}, 32'd1);
    cyc();
    i_ll_valid = 1'b0;
    @(negedge i_clk);
    chk("x0_ll_WE3", {31'd0, o_WE3}, 32'd0);

    // Mixed traffic, checked by the compare process against the model.
    wb_pat = 16'b1111_1110_1111_1011;
    for (int c = 0; c < 48; c++) begin
      i_wb_valid = wb_pat[c % 16];
      i_wb_rd    = 5'((c * 5 + 1) % 32);
      i_wb_data  = 32'h1000 + 32'(c);
      if (!i_ll_valid && (c % 3 == 0)) begin
        i_ll_valid = 1'b1;
        i_ll_rd    = 5'((c * 7 + 3) % 32);
        i_ll_data  = 32'hA000 + 32'(c);
      end
      i_ll_issue    = (c % 5 == 0);
      i_ll_issue_rd = 5'((c * 3 + 2) % 32);
      @(negedge i_clk);
      g = m_ll_wins();
      cyc();
      if (g) i_ll_valid = 1'b0;
    end
    idle_inputs();

    // Reset mid-operation: pending busy bit and a write in flight.
    cyc();
    i_ll_issue    = 1'b1;
    i_ll_issue_rd = 5'd20;
    i_ll_valid    = 1'b1;
    i_ll_rd       = 5'd21;
    i_ll_data     = 32'h2121;
    @(negedge i_clk);
    chk("mid_ready", {31'd0, o_ll_ready}, 32'd1);
    cyc();
    idle_inputs();
    chk("mid_we_pre",   {31'd0, o_WE3},     32'd1);
    chk("mid_busy_pre", {31'd0, o_busy[20]}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_WE3",  {31'd0, o_WE3},     32'd0);
    chk("mid_rst_busy", o_busy,             32'd0);
    chk("mid_rst_A3",   {27'd0, o_A3_addr}, 32'd0);
    chk("mid_rst_WD3",  o_WD3_data,         32'd0);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (3) cyc();
    @(negedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
